// File: rtl/fwd_unit_param.sv
// fwd_unit_param: ID/EX operand forwarding against MEM, WB and a retired-write history,
// with load-use stall detection and registered operand output.
module fwd_unit_param #(
    parameter int         XLEN       = 32,
    parameter int         RBITS      = 5,
    parameter int         NSRC       = 2,
    parameter int         HIST_DEPTH = 2,
    parameter logic [6:0] LOAD_OP    = 7'b0000011
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ex_valid,
    input  logic [NSRC*RBITS-1:0] ex_rs,
    input  logic [NSRC*XLEN-1:0] rf_data,
    input  logic                 mem_we,
    input  logic [RBITS-1:0]     mem_rd,
    input  logic [6:0]           mem_op,
    input  logic [XLEN-1:0]      mem_alu,
    input  logic [XLEN-1:0]      mem_ld_data,
    input  logic                 mem_ld_vld,
    input  logic                 wb_we,
    input  logic [RBITS-1:0]     wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 hist_flush,
    output logic                 stall,
    output logic                 src_vld,
    output logic [NSRC*XLEN-1:0] src_data,
    output logic [NSRC-1:0]      src_hit
);

    logic [HIST_DEPTH-1:0] hist_v;
    logic [RBITS-1:0]      hist_rd   [HIST_DEPTH];
    logic [XLEN-1:0]       hist_data [HIST_DEPTH];

    logic [NSRC*XLEN-1:0]  fwd_data;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC-1:0]       load_use;
    logic                  mem_is_load;
    logic                  hist_push;
    logic                  capture;

    assign mem_is_load = mem_op == LOAD_OP;
    assign hist_push   = wb_we && wb_rd != '0;
    assign stall       = ex_valid && |load_use;
    assign capture     = ex_valid && !stall;

    // Resolve each source; sources are applied lowest priority first so later matches win.
    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = '0;
        load_use = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_rs[i*RBITS +: RBITS] != '0) begin
                for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                    if (hist_v[k] && hist_rd[k] == ex_rs[i*RBITS +: RBITS]) begin
                        fwd_data[i*XLEN +: XLEN] = hist_data[k];
                        fwd_hit[i]               = 1'b1;
                    end
                end
                if (wb_we && wb_rd == ex_rs[i*RBITS +: RBITS]) begin
                    fwd_data[i*XLEN +: XLEN] = wb_data;
                    fwd_hit[i]               = 1'b1;
                end
                if (mem_we && mem_rd == ex_rs[i*RBITS +: RBITS]) begin
                    fwd_data[i*XLEN +: XLEN] = mem_is_load ? mem_ld_data : mem_alu;
                    fwd_hit[i]               = 1'b1;
                    load_use[i]              = mem_is_load && !mem_ld_vld;
                end
            end
        end
    end

    // Register the resolved operand set when the instruction is not stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_vld  <= 1'b0;
            src_data <= '0;
            src_hit  <= '0;
        end else begin
            src_vld <= capture;
            if (capture) begin
                src_data <= fwd_data;
                src_hit  <= fwd_hit;
            end
        end
    end

    // Retired-write history: shift in each nonzero WB write; flush clears all but a same-edge push.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist_v <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_rd[k]   <= '0;
                hist_data[k] <= '0;
            end
        end else if (hist_push) begin
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                hist_v[k]    <= hist_v[k-1] && !hist_flush;
                hist_rd[k]   <= hist_rd[k-1];
                hist_data[k] <= hist_data[k-1];
            end
            hist_v[0]    <= 1'b1;
            hist_rd[0]   <= wb_rd;
            hist_data[0] <= wb_data;
        end else if (hist_flush) begin
            hist_v <= '0;
        end
    end

endmodule
